// File: rtl/data_memory_sized.sv
// Byte-addressable big-endian data memory: byte/half/word accesses, sign extension,
// registered one-cycle read with valid/error strobes, and a post-reset clear sequencer.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_INIT | clear sequencer zeroing word wcnt; requests ignored
// ST_IDLE | accepting read/write requests
module data_memory_sized #(
  parameter int ADDR_BITS      = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dm_cs,
  input  logic        dm_wr,
  input  logic        dm_rd,
  input  logic [1:0]  dm_size,
  input  logic        dm_signed,
  input  logic [31:0] Address,
  input  logic [31:0] D_In,
  output logic [31:0] D_Out,
  output logic        dm_valid,
  output logic        dm_err,
  output logic        dm_busy
);

  localparam int WORD_BITS = ADDR_BITS - 2;
  localparam int DEPTH     = 1 << WORD_BITS;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  logic [0:0]           state;
  logic [WORD_BITS-1:0] wcnt;
  logic [31:0]          mem [DEPTH];

  logic [ADDR_BITS-1:0] a;
  logic [WORD_BITS-1:0] widx;
  logic [1:0]           lane;
  logic                 addr_unused;

  logic        req, illegal, idle, accept_wr, accept_rd;
  logic [3:0]  be;
  logic [31:0] wdata, rword, shifted, rdata;

  assign a           = Address[ADDR_BITS-1:0];
  assign widx        = a[ADDR_BITS-1:2];
  assign lane        = a[1:0];
  assign addr_unused = ^Address[31:ADDR_BITS];

  assign idle    = (state == ST_IDLE);
  assign dm_busy = (state == ST_INIT);
  assign req     = dm_cs & (dm_wr | dm_rd);
  assign illegal = (dm_wr & dm_rd) | (dm_size == 2'b11) |
                   ((dm_size == 2'b01) & lane[0]) |
                   ((dm_size == 2'b10) & (lane != 2'b00));
  assign accept_wr = idle & req & ~illegal & dm_wr;
  assign accept_rd = idle & req & ~illegal & dm_rd;

  // Byte enable bit 3 is the lowest address in the word (most significant lane).
  always_comb begin
    be    = 4'b0000;
    wdata = D_In;
    case (dm_size)
      2'b00: begin
        be    = 4'b1000 >> lane;
        wdata = {4{D_In[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b0011 : 4'b1100;
        wdata = {2{D_In[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign rword   = mem[widx];
  assign shifted = rword << {lane, 3'b000};

  always_comb begin
    case (dm_size)
      2'b00:   rdata = {{24{dm_signed & shifted[31]}}, shifted[31:24]};
      2'b01:   rdata = {{16{dm_signed & shifted[31]}}, shifted[31:16]};
      default: rdata = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_INIT) begin
        mem[wcnt] <= '0;
      end else if (accept_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
      wcnt     <= '0;
      D_Out    <= '0;
      dm_valid <= 1'b0;
      dm_err   <= 1'b0;
    end else begin
      dm_valid <= accept_rd;
      dm_err   <= idle & req & illegal;
      if (accept_rd) D_Out <= rdata;
      if (state == ST_INIT) begin
        wcnt <= wcnt + 1'b1;
        if (&wcnt) state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Self-checking bench for data_memory_sized: directed lane/error/clear scenarios plus
// randomized traffic compared against a byte-array reference model.
module tb_data_memory_sized;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dm_cs = 1'b0, dm_wr = 1'b0, dm_rd = 1'b0, dm_signed = 1'b0;
  logic [1:0]  dm_size = 2'b00;
  logic [31:0] Address = '0, D_In = '0;
  logic [31:0] D_Out;
  logic        dm_valid, dm_err, dm_busy;

  int checks = 0;
  int failures = 0;

  logic [7:0]  ref_mem [4096];
  logic [31:0] exp_dout;

  data_memory_sized #(.ADDR_BITS(12), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .dm_cs(dm_cs), .dm_wr(dm_wr), .dm_rd(dm_rd),
    .dm_size(dm_size), .dm_signed(dm_signed), .Address(Address), .D_In(D_In),
    .D_Out(D_Out), .dm_valid(dm_valid), .dm_err(dm_err), .dm_busy(dm_busy)
  );

  always #5 clk = ~clk;

  // Reference: memory is a flat byte array, lowest address is most significant.
  function automatic void model(input logic cs, wr, rd, input logic [1:0] size,
                                input logic sgn, input logic [31:0] addr, din,
                                output logic ev, output logic ee);
    int base, n;
    logic ill, req;
    logic [31:0] v;
    base = int'(addr[11:0]);
    n = 1 << size;
    req = cs && (wr || rd);
    ill = (wr && rd) || size == 2'd3 || (size == 2'd1 && base % 2 != 0) ||
          (size == 2'd2 && base % 4 != 0);
    ev = req && !ill && rd;
    ee = req && ill;
    if (req && !ill && wr)
      for (int i = 0; i < n; i++) ref_mem[base + i] = din[8*(n-1-i) +: 8];
    if (ev) begin
      v = '0;
      for (int i = 0; i < n; i++) v = {v[23:0], ref_mem[base + i]};
      if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      exp_dout = v;
    end
  endfunction

  task automatic step(input logic cs, wr, rd, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, din);
    dm_cs = cs; dm_wr = wr; dm_rd = rd; dm_size = size; dm_signed = sgn;
    Address = addr; D_In = din;
    @(posedge clk); #1;
    dm_cs = 1'b0; dm_wr = 1'b0; dm_rd = 1'b0;
  endtask

  // Runs the clear from a just-released reset; optionally injects a write then read.
  task automatic wait_clear(input int req_at, input logic [31:0] req_addr,
                            output int n, output int spurious);
    n = 0;
    spurious = 0;
    while (dm_busy && n < 3000) begin
      if (n == req_at) step(1, 1, 0, 2'd2, 0, req_addr, 32'hFFFF_FFFF);
      else if (n == req_at + 1) step(1, 0, 1, 2'd2, 0, req_addr, 32'h0);
      else step(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
      if (dm_valid || dm_err) spurious++;
      n++;
    end
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    exp_dout = '0;
  endtask

  task automatic test_reset;
    int n, sp;
    logic ev, ee;
    logic [31:0] addrs [4];
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({dm_busy, dm_valid, dm_err, D_Out} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL reset_state: busy=%0b valid=%0b err=%0b dout=%h, expected 1 0 0 00000000",
               dm_busy, dm_valid, dm_err, D_Out);
    end
    reset = 1'b0;
    wait_clear(10, 32'h100, n, sp);
    checks++;
    if (n !== 1024) begin
      failures++; $display("FAIL clear_length: busy cycles=%0d, expected 1024", n);
    end
    checks++;
    if (sp !== 0) begin
      failures++; $display("FAIL busy_ignore: responses during clear=%0d, expected 0", sp);
    end
    addrs = '{32'h000, 32'h7FC, 32'hFFC, 32'h100};
    foreach (addrs[i]) begin
      model(1, 0, 1, 2'd2, 0, addrs[i], 0, ev, ee);
      step(1, 0, 1, 2'd2, 0, addrs[i], 0);
      checks++;
      if ({dm_valid, dm_err, D_Out} !== {1'b1, 1'b0, 32'h0}) begin
        failures++;
        $display("FAIL cleared_read[%h]: valid=%0b err=%0b dout=%h, expected 1 0 00000000",
                 addrs[i], dm_valid, dm_err, D_Out);
      end
    end
    step(0, 0, 0, 2'd0, 0, 0, 0);
    checks++;
    if (dm_valid !== 1'b0) begin
      failures++; $display("FAIL valid_falls: valid=%0b, expected 0", dm_valid);
    end
  endtask

  task automatic test_sign_ext;
    logic ev, ee;
    logic [31:0] exp [5];
    logic [1:0]  sz [5];
    logic        sg [5];
    logic [31:0] ad [5];
    exp = '{32'hFFFF_FF80, 32'hFFFF_FFFF, 32'h0000_0012, 32'h0000_0034, 32'h0000_80FF};
    ad  = '{32'h010, 32'h011, 32'h012, 32'h013, 32'h010};
    sz  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    sg  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    model(1, 1, 0, 2'd2, 0, 32'h010, 32'h80FF_1234, ev, ee);
    step(1, 1, 0, 2'd2, 0, 32'h010, 32'h80FF_1234);
    foreach (exp[i]) begin
      model(1, 0, 1, sz[i], sg[i], ad[i], 0, ev, ee);
      step(1, 0, 1, sz[i], sg[i], ad[i], 0);
      checks++;
      if ({dm_valid, dm_err, D_Out} !== {1'b1, 1'b0, exp[i]}) begin
        failures++;
        $display("FAIL sign_ext[%0d]: valid=%0b err=%0b dout=%h, expected 1 0 %h",
                 i, dm_valid, dm_err, D_Out, exp[i]);
      end
    end
  endtask

  task automatic test_write_lanes;
    logic ev, ee;
    model(1, 1, 0, 2'd0, 0, 32'h021, 32'h0000_00A5, ev, ee);
    step(1, 1, 0, 2'd0, 0, 32'h021, 32'h0000_00A5);
    model(1, 0, 1, 2'd2, 0, 32'h020, 0, ev, ee);
    step(1, 0, 1, 2'd2, 0, 32'h020, 0);
    checks++;
    if ({dm_valid, D_Out} !== {1'b1, 32'h00A5_0000}) begin
      failures++;
      $display("FAIL byte_lane: valid=%0b dout=%h, expected 1 00a50000", dm_valid, D_Out);
    end
    model(1, 1, 0, 2'd1, 0, 32'h022, 32'h0000_7E01, ev, ee);
    step(1, 1, 0, 2'd1, 0, 32'h022, 32'h0000_7E01);
    model(1, 0, 1, 2'd2, 0, 32'h020, 0, ev, ee);
    step(1, 0, 1, 2'd2, 0, 32'h020, 0);
    checks++;
    if ({dm_valid, D_Out} !== {1'b1, 32'h00A5_7E01}) begin
      failures++;
      $display("FAIL half_lane: valid=%0b dout=%h, expected 1 00a57e01", dm_valid, D_Out);
    end
  endtask

  task automatic test_illegal;
    logic ev, ee;
    logic [31:0] held;
    logic [1:0]  sz [4];
    logic        wr [4], rd [4];
    logic [31:0] ad [4];
    sz = '{2'd2, 2'd1, 2'd3, 2'd2};
    wr = '{1'b0, 1'b1, 1'b0, 1'b1};
    rd = '{1'b1, 1'b0, 1'b1, 1'b1};
    ad = '{32'h013, 32'h031, 32'h030, 32'h030};
    model(1, 1, 0, 2'd2, 0, 32'h030, 32'h1122_3344, ev, ee);
    step(1, 1, 0, 2'd2, 0, 32'h030, 32'h1122_3344);
    model(1, 0, 1, 2'd2, 0, 32'h010, 0, ev, ee);
    step(1, 0, 1, 2'd2, 0, 32'h010, 0);
    held = exp_dout;
    foreach (sz[i]) begin
      model(1, wr[i], rd[i], sz[i], 0, ad[i], 32'hCAFE_F00D, ev, ee);
      step(1, wr[i], rd[i], sz[i], 0, ad[i], 32'hCAFE_F00D);
      checks++;
      if ({dm_valid, dm_err, D_Out} !== {1'b0, 1'b1, held}) begin
        failures++;
        $display("FAIL illegal[%0d]: valid=%0b err=%0b dout=%h, expected 0 1 %h",
                 i, dm_valid, dm_err, D_Out, held);
      end
    end
    model(1, 0, 1, 2'd2, 0, 32'h030, 0, ev, ee);
    step(1, 0, 1, 2'd2, 0, 32'h030, 0);
    checks++;
    if ({dm_valid, dm_err, D_Out} !== {1'b1, 1'b0, 32'h1122_3344}) begin
      failures++;
      $display("FAIL illegal_untouched30: valid=%0b err=%0b dout=%h, expected 1 0 11223344",
               dm_valid, dm_err, D_Out);
    end
    model(1, 0, 1, 2'd2, 0, 32'h010, 0, ev, ee);
    step(1, 0, 1, 2'd2, 0, 32'h010, 0);
    checks++;
    if (D_Out !== 32'h80FF_1234) begin
      failures++;
      $display("FAIL illegal_untouched10: dout=%h, expected 80ff1234", D_Out);
    end
  endtask

  task automatic test_back_to_back;
    logic ev, ee;
    logic [31:0] vals [3];
    vals = '{32'h0101_A0A0, 32'h2222_B1B1, 32'h3C3C_4D4D};
    for (int i = 0; i < 3; i++) begin
      model(1, 1, 0, 2'd2, 0, 32'(4*i), vals[i], ev, ee);
      step(1, 1, 0, 2'd2, 0, 32'(4*i), vals[i]);
    end
    for (int i = 0; i < 3; i++) begin
      model(1, 0, 1, 2'd2, 0, 32'(4*i), 0, ev, ee);
      step(1, 0, 1, 2'd2, 0, 32'(4*i), 0);
      checks++;
      if ({dm_valid, dm_err, D_Out} !== {1'b1, 1'b0, vals[i]}) begin
        failures++;
        $display("FAIL b2b[%0d]: valid=%0b err=%0b dout=%h, expected 1 0 %h",
                 i, dm_valid, dm_err, D_Out, vals[i]);
      end
    end
  endtask

  task automatic test_random;
    logic ev, ee, cs, wr, rd, sg;
    logic [1:0]  sz;
    logic [31:0] ad, din;
    int bad = 0;
    for (int k = 0; k < 600; k++) begin
      cs = ($urandom_range(0, 7) != 0);
      wr = $urandom_range(0, 1);
      rd = ($urandom_range(0, 3) != 0) ? ~wr : wr;
      sz = 2'($urandom_range(0, 3));
      sg = $urandom_range(0, 1);
      ad = ($urandom & 32'hFFFF_F000) |
           32'($urandom_range(0, 3) == 0 ? $urandom_range(4032, 4095) : $urandom_range(0, 63));
      if ($urandom_range(0, 4) != 0) begin
        if (sz == 2'd1) ad[0] = 1'b0;
        if (sz == 2'd2) ad[1:0] = 2'b00;
      end
      din = $urandom;
      model(cs, wr, rd, sz, sg, ad, din, ev, ee);
      step(cs, wr, rd, sz, sg, ad, din);
      checks++;
      if ({dm_valid, dm_err, D_Out, dm_busy} !== {ev, ee, exp_dout, 1'b0}) begin
        failures++;
        if (bad < 10)
          $display("FAIL random[%0d]: valid=%0b err=%0b dout=%h busy=%0b, expected %0b %0b %h 0",
                   k, dm_valid, dm_err, D_Out, dm_busy, ev, ee, exp_dout);
        bad++;
      end
    end
  endtask

  task automatic test_reset_mid_init;
    int n, sp;
    logic ev, ee;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (500) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_clear(3, 32'h200, n, sp);
    checks++;
    if (n !== 1024) begin
      failures++; $display("FAIL restart_clear: busy cycles=%0d, expected 1024", n);
    end
    checks++;
    if (sp !== 0) begin
      failures++; $display("FAIL restart_ignore: responses=%0d, expected 0", sp);
    end
    model(1, 0, 1, 2'd2, 0, 32'h200, 0, ev, ee);
    step(1, 0, 1, 2'd2, 0, 32'h200, 0);
    checks++;
    if ({dm_valid, D_Out} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL busy_write_dropped: valid=%0b dout=%h, expected 1 00000000", dm_valid, D_Out);
    end
  endtask

  task automatic test_reset_mid_read;
    int n, sp;
    logic ev, ee;
    model(1, 1, 0, 2'd2, 0, 32'h044, 32'hDEAD_BEEF, ev, ee);
    step(1, 1, 0, 2'd2, 0, 32'h044, 32'hDEAD_BEEF);
    reset = 1'b1;
    step(1, 0, 1, 2'd2, 0, 32'h044, 0);
    checks++;
    if ({dm_valid, dm_err, D_Out, dm_busy} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL reset_read: valid=%0b err=%0b dout=%h busy=%0b, expected 0 0 00000000 1",
               dm_valid, dm_err, D_Out, dm_busy);
    end
    reset = 1'b0;
    wait_clear(-5, 32'h0, n, sp);
    model(1, 0, 1, 2'd2, 0, 32'h044, 0, ev, ee);
    step(1, 0, 1, 2'd2, 0, 32'h044, 0);
    checks++;
    if ({n, dm_valid, D_Out} !== {32'd1024, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL reclear: cycles=%0d valid=%0b dout=%h, expected 1024 1 00000000",
               n, dm_valid, D_Out);
    end
  endtask

  initial begin
    exp_dout = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_sign_ext();
    test_write_lanes();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid_init();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_sized.md
# data_memory_sized

Parametrised, byte-addressable, big-endian data memory for the integer datapath. It supports byte, halfword and word accesses with optional sign extension and a registered one-cycle read with a valid strobe. Misaligned or illegal requests are trapped. A reset-time clear sequencer zeroes the array. It sits between the ALU address path and the write-back mux, in the same position as the current word-only data memory.

## Interface

Parameters:
- ADDR_BITS, 12, byte-address width used; array holds 2^ADDR_BITS bytes (2^(ADDR_BITS-2) words).
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = contents undefined, ready immediately.

Ports:
- clk  input  1  single clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- dm_cs  input  1  chip select.
- dm_wr  input  1  write request.
- dm_rd  input  1  read request.
- dm_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- dm_signed  input  1  reads only: 1 = sign-extend, 0 = zero-extend.
- Address  input  32  byte address; only Address[ADDR_BITS-1:0] is used, upper bits ignored.
- D_In  input  32  write data, right-justified (byte in [7:0], half in [15:0]).
- D_Out  output  32  registered read data, extended to 32 bits.
- dm_valid  output  1  one-cycle pulse: D_Out carries the result of the previous cycle's read.
- dm_err  output  1  one-cycle pulse: the previous cycle's request was rejected.
- dm_busy  output  1  clear sequencer active; requests ignored.

## Operation

- FSM has two states: INIT and IDLE.
  - Reset enters INIT if CLEAR_ON_RESET=1, otherwise IDLE.
  - INIT writes 0 to word index wcnt each cycle, with wcnt running 0 to 2^(ADDR_BITS-2)-1, then moves to IDLE.
  - dm_busy = (state==INIT).
- A request is any cycle with dm_cs=1 and (dm_wr|dm_rd)=1.
  - Requests while dm_busy=1 are ignored: no write, no dm_valid, no dm_err.
- An IDLE request is illegal if any of these hold:
  - dm_wr and dm_rd are both 1;
  - dm_size=11;
  - halfword with Address[0]=1;
  - word with Address[1:0]!=00.
- Illegal request: memory unchanged, D_Out holds, dm_err=1 next cycle, dm_valid=0.
- Byte lanes are big-endian; A = Address[ADDR_BITS-1:0]. The byte at A is the most significant.
  - Write byte: M[A]<=D_In[7:0].
  - Write half: M[A]<=D_In[15:8], M[A+1]<=D_In[7:0].
  - Write word: M[A..A+3]<=D_In[31:0], MSB first.
- Read returns the same lane order, right-justified. Bits above the access size are filled with the access MSB if dm_signed=1, else 0.
- Legal accesses are aligned, so no access crosses the array top. Address bits above ADDR_BITS-1 alias (wrap) silently.
- D_Out holds its last read value between reads. It is never tri-stated and is not updated by writes or errors.

## Timing

- Reset values: D_Out=0, dm_valid=0, dm_err=0, wcnt=0.
  - dm_busy=1 from the first edge with reset=1 if CLEAR_ON_RESET=1, else 0.
- Clear duration: dm_busy stays 1 for exactly 2^(ADDR_BITS-2) cycles after the last reset cycle (1024 at default). The first request is accepted in the cycle dm_busy reads 0.
- Reset asserted mid-INIT restarts the clear from wcnt=0. Reset mid-read suppresses the pending dm_valid.
- Write is committed at the accepting edge. A read of the same address in the very next cycle returns the new data.
- Read latency is 1: request sampled at edge N; D_Out and dm_valid=1 appear after edge N. dm_valid falls after edge N+1 unless another read is accepted.
- Back-to-back reads give one result per cycle, and dm_valid stays high continuously.
- dm_err follows the same one-cycle latency as dm_valid; the two are never both 1.

## Test plan

- Reset with CLEAR_ON_RESET=1, ADDR_BITS=12 -> dm_busy=1 for exactly 1024 cycles. Word reads of 0x000, 0x7FC and 0xFFC then return 0x00000000 with dm_valid one cycle after each request.
- Write word 0x80FF1234 at 0x010; read bytes 0x010–0x013 with dm_signed=1 -> 0xFFFFFF80, 0xFFFFFFFF, 0x00000012, 0x00000034. Read half 0x010 with dm_signed=0 -> 0x000080FF.
- Write byte 0xA5 at 0x021 over a zero word; read word 0x020 -> 0x00A50000. Write half 0x7E01 at 0x022; read word 0x020 -> 0x00A57E01.
- Illegal cases: word read at 0x013, half write at 0x031, dm_size=11, and wr&rd together. Each -> dm_err pulse next cycle, dm_valid=0, D_Out unchanged, target memory unchanged on readback.
- Back-to-back word reads of 0x000, 0x004 and 0x008, each preloaded with distinct values -> dm_valid high for 3 consecutive cycles with matching D_Out. A request issued during INIT -> no response, and memory is still zero after the clear.
- Assert reset at INIT cycle 500 for 1 cycle -> dm_busy stays high another 1024 cycles; a write during that window has no effect.
